seq_fsm_prog: RTL
=================

Name: seq_fsm_prog

Overview:
- Programmable, clocked successor to the fixed 4-state input-steered FSM.
- State count, input width and output width are parameters.
- Each state's trigger bit, trigger polarity, next state and per-output-bit input select come from a run-time writable config table.
- Used wherever a small input-sequenced controller is needed; also provides transition pulse/count observability for checkers.

Parameters:
- N_IN, 4, width of `in`; must be >= 2.
- N_OUT, 2, width of `out`; must be >= 1.
- N_STATES, 4, number of states; must be >= 2.
- CNT_W, 16, width of the transition counter.
- Derived, not overridable:
  - SEL_W = $clog2(N_IN)
  - ST_W = $clog2(N_STATES)
  - ENTRY_W = 1 + SEL_W + ST_W + N_OUT*SEL_W

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable.
- clr  in  1  synchronous return to state 0.
- in  in  N_IN  steering/data inputs.
- out  out  N_OUT  combinational output: out[j] = in[entry[state].out_sel[j]].
- state_o  out  ST_W  current registered state.
- adv  out  1  registered one-cycle pulse, high in the cycle after a taken transition.
- trans_cnt  out  CNT_W  count of taken transitions; wraps.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  ST_W  entry index for write and readback.
- cfg_wdata  in  ENTRY_W  entry to write.
- cfg_rdata  out  ENTRY_W  combinational readback of entry[cfg_addr]; 0 if addr out of range.
- cfg_err  out  1  registered pulse, high in the cycle after a rejected write.

Behaviour:
- Entry layout, LSB first:
  - trig_sel[SEL_W]
  - trig_pol[1]
  - next[ST_W]
  - out_sel[0..N_OUT-1], each SEL_W wide; out_sel[0] is the lowest field.
- Reset (rst_n low, asynchronous): state=0, adv=0, trans_cnt=0, cfg_err=0.
- Reset loads the default table; for k in 0..N_STATES-1:
  - trig_sel = k mod N_IN
  - trig_pol = 1
  - next = (k+1) mod N_STATES
  - out_sel[j] = (k+j) mod N_IN
- Taken transition: en=1, clr=0 and in[entry[state].trig_sel] == trig_pol.
  - Next edge: state <= entry[state].next, adv <= 1, trans_cnt <= trans_cnt+1 (mod 2^CNT_W).
  - Otherwise state holds and adv <= 0.
- Self-loop entries (next == current state) still count as taken: adv pulses and trans_cnt increments.
- clr=1: next edge forces state <= 0 and adv <= 0.
  - clr overrides en and the trigger.
  - clr leaves trans_cnt and the config table unchanged.
- en=0: state holds; out still tracks `in` combinationally.
- Config write (cfg_we=1): entry[cfg_addr] <= cfg_wdata at the edge.
  - The write is rejected (entry unchanged, cfg_err pulses 1 cycle) if any of these hold: cfg_addr >= N_STATES, next >= N_STATES, trig_sel >= N_IN, or any out_sel >= N_IN.
- Write and transition in the same cycle: the transition uses the old entry; the new entry is effective from the next cycle. `out` switches to the new entry one cycle after the write.
- Write and clr in the same cycle: both take effect.
- Reset mid-operation discards all written entries and restores the default table.
- state_o is never >= N_STATES; guaranteed by the write validation.
- `out` has no latency from `in`. `out` changes one cycle after a taken transition (new state's selects).

Decomposition:
- Package seq_fsm_prog_pkg holds:
  - entry field offset/width functions parameterised by N_IN, N_OUT, N_STATES;
  - default-entry function default_entry(k);
  - entry validation function entry_ok().
- One sub-module, seq_fsm_prog_cfg_tbl, contains:
  - the register array with reset defaults, write validation and cfg_err;
  - readback port and current-state read port.
- The top contains the state register, transition logic, counter and output mux.

Test Plan:
- Reset, defaults, en=1, in=4'b0001 held → state 0→1 (trig bit 0 pol 1); next cycle adv=1, trans_cnt=1. Then in=4'b0000 → state holds at 1, adv=0.
- Output mux check: state 2, in=4'b0110 → out = {in[3],in[2]} = 2'b01; state 3 → out = {in[0],in[3]} = 2'b00.
- Invalid config: write addr 1 with trig_pol=0, trig_sel=3, next=0. Then state 1, in[3]=0, en=1 → state 0, adv=1. A write with addr=1 and out_sel of 3 is accepted. With N_IN=3, a write with trig_sel=3 → cfg_err=1 for one cycle, cfg_rdata unchanged.
- Write/transition collision: state 0, in[0]=1, same-cycle write to entry 0 with next=3 → state goes to 1 (old entry). Return to 0 and trigger again → state 3.
- clr priority: state 2 with trigger true, clr=1, en=1 → state 0, adv=0, trans_cnt unchanged.
- Async reset mid-run: rst_n low for half a cycle at state 3, trans_cnt=5, custom table → state 0, trans_cnt 0, cfg_rdata(addr 0) = default_entry(0) immediately, without a clock edge.
- Counter wrap: CNT_W=2, 5 taken transitions → trans_cnt=1.

Source files
------------

// File: rtl/seq_fsm_prog_pkg.sv
// Shared helpers for the programmable sequencer: config entry field layout,
// default table contents and write validation.
//
// Entry layout, LSB first:
//   trig_sel[SEL_W] | trig_pol[1] | next[ST_W] | out_sel[0] .. out_sel[N_OUT-1]
//
// Every helper takes the block parameters as arguments, so one package serves
// any instance size.
package seq_fsm_prog_pkg;

  // Widest entry the helpers handle; callers slice down to their ENTRY_W.
  localparam int MAX_ENTRY_W = 64;
  typedef logic [MAX_ENTRY_W-1:0] entry_t;

  function automatic int sel_w(input int n_in);
    return $clog2(n_in);
  endfunction

  function automatic int st_w(input int n_states);
    return $clog2(n_states);
  endfunction

  function automatic int entry_w(input int n_in, input int n_out, input int n_states);
    return 1 + sel_w(n_in) + st_w(n_states) + n_out * sel_w(n_in);
  endfunction

  // Field offsets within an entry.
  function automatic int off_trig_sel();
    return 0;
  endfunction

  function automatic int off_trig_pol(input int n_in);
    return sel_w(n_in);
  endfunction

  function automatic int off_next(input int n_in);
    return sel_w(n_in) + 1;
  endfunction

  function automatic int off_out_sel(input int n_in, input int n_states, input int j);
    return sel_w(n_in) + 1 + st_w(n_states) + j * sel_w(n_in);
  endfunction

  // Extract an unsigned field.
  function automatic int get_field(input entry_t e, input int off, input int w);
    entry_t m;
    m = (entry_t'(1) << w) - entry_t'(1);
    return int'((e >> off) & m);
  endfunction

  // Insert an unsigned field; the target bits are assumed to be zero.
  function automatic entry_t put_field(input entry_t e, input int off, input int w, input int v);
    entry_t m;
    m = (entry_t'(1) << w) - entry_t'(1);
    return e | ((entry_t'(v) & m) << off);
  endfunction

  // Default entry k: trigger on in[k mod N_IN] high, step to k+1, and rotate
  // the output selects so each state shows a different input window.
  function automatic entry_t default_entry(input int k, input int n_in,
                                           input int n_out, input int n_states);
    entry_t e;
    e = '0;
    e = put_field(e, off_trig_sel(), sel_w(n_in), k % n_in);
    e = put_field(e, off_trig_pol(n_in), 1, 1);
    e = put_field(e, off_next(n_in), st_w(n_states), (k + 1) % n_states);
    for (int j = 0; j < n_out; j++)
      e = put_field(e, off_out_sel(n_in, n_states, j), sel_w(n_in), (k + j) % n_in);
    return e;
  endfunction

  // An entry is usable only if every select addresses a real input and the
  // successor is a real state; this keeps the state register in range.
  function automatic logic entry_ok(input entry_t e, input int n_in,
                                    input int n_out, input int n_states);
    logic ok;
    ok = 1'b1;
    if (get_field(e, off_trig_sel(), sel_w(n_in)) >= n_in) ok = 1'b0;
    if (get_field(e, off_next(n_in), st_w(n_states)) >= n_states) ok = 1'b0;
    for (int j = 0; j < n_out; j++)
      if (get_field(e, off_out_sel(n_in, n_states, j), sel_w(n_in)) >= n_in) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/seq_fsm_prog_cfg_tbl.sv
// Config table for the programmable sequencer: one entry per state, loaded
// with defaults at reset, validated writes, readback and current-state port.
module seq_fsm_prog_cfg_tbl
  import seq_fsm_prog_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 2,
  parameter int N_STATES = 4,
  localparam int ST_W    = $clog2(N_STATES),
  localparam int ENTRY_W = 1 + $clog2(N_IN) + $clog2(N_STATES) + N_OUT * $clog2(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ST_W-1:0]    addr,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               err,
  input  logic [ST_W-1:0]    cur_state,
  output logic [ENTRY_W-1:0] cur_entry
);

  logic [ENTRY_W-1:0] tbl [N_STATES];
  logic               addr_ok;
  logic               wr_ok;

  assign addr_ok = int'(addr) < N_STATES;
  assign wr_ok   = addr_ok && entry_ok(entry_t'(wdata), N_IN, N_OUT, N_STATES);

  // Table storage: defaults on reset, accepted writes land at the edge,
  // rejected writes leave the entry alone and raise a one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_STATES; k++)
        tbl[k] <= ENTRY_W'(default_entry(k, N_IN, N_OUT, N_STATES));
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (we) begin
        if (wr_ok) tbl[addr] <= wdata;
        else       err       <= 1'b1;
      end
    end
  end

  // Readback returns zero for addresses beyond the last state.
  always_comb begin
    rdata = '0;
    if (addr_ok) rdata = tbl[addr];
  end

  // The state register never leaves range, so no guard is needed here.
  assign cur_entry = tbl[cur_state];

endmodule

// File: rtl/seq_fsm_prog.sv
// Programmable input-steered sequencer. The current state's config entry
// picks a trigger input and polarity (advance condition), the successor
// state, and which input drives each output bit.
module seq_fsm_prog
  import seq_fsm_prog_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 2,
  parameter int N_STATES = 4,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(N_IN),
  localparam int ST_W    = $clog2(N_STATES),
  localparam int ENTRY_W = 1 + SEL_W + ST_W + N_OUT * SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [N_IN-1:0]    in,
  output logic [N_OUT-1:0]   out,
  output logic [ST_W-1:0]    state_o,
  output logic               adv,
  output logic [CNT_W-1:0]   trans_cnt,
  input  logic               cfg_we,
  input  logic [ST_W-1:0]    cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  output logic [ENTRY_W-1:0] cfg_rdata,
  output logic               cfg_err
);

  localparam int OFF_POL  = SEL_W;
  localparam int OFF_NEXT = SEL_W + 1;
  localparam int OFF_OSEL = SEL_W + 1 + ST_W;

  logic [ST_W-1:0]             state;
  logic [ENTRY_W-1:0]          cur_entry;
  logic [SEL_W-1:0]            trig_sel;
  logic                        trig_pol;
  logic [ST_W-1:0]             next_st;
  logic [N_OUT-1:0][SEL_W-1:0] out_sel;
  logic                        taken;

  seq_fsm_prog_cfg_tbl #(
    .N_IN     (N_IN),
    .N_OUT    (N_OUT),
    .N_STATES (N_STATES)
  ) u_tbl (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (cfg_we),
    .addr      (cfg_addr),
    .wdata     (cfg_wdata),
    .rdata     (cfg_rdata),
    .err       (cfg_err),
    .cur_state (state),
    .cur_entry (cur_entry)
  );

  assign trig_sel = cur_entry[SEL_W-1:0];
  assign trig_pol = cur_entry[OFF_POL];
  assign next_st  = cur_entry[OFF_NEXT +: ST_W];

  // Output mux: each bit follows its selected input with no latency.
  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign out_sel[j] = cur_entry[OFF_OSEL + j*SEL_W +: SEL_W];
    assign out[j]     = in[out_sel[j]];
  end

  // A transition is taken when enabled, not clearing, and the selected
  // input matches the programmed polarity; self-loops count as taken.
  assign taken = en && !clr && (in[trig_sel] == trig_pol);

  // State, advance pulse and transition counter. clr wins over everything
  // but leaves the counter alone; a same-cycle table write only affects the
  // entry seen from the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= '0;
      adv       <= 1'b0;
      trans_cnt <= '0;
    end else if (clr) begin
      state <= '0;
      adv   <= 1'b0;
    end else if (taken) begin
      state     <= next_st;
      adv       <= 1'b1;
      trans_cnt <= trans_cnt + CNT_W'(1);
    end else begin
      adv <= 1'b0;
    end
  end

  assign state_o = state;

endmodule
